// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package hazard_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        KILL  = 2'd2
    } state_t;

    localparam state_t           RST_STATE     = RUN;
    localparam logic [XLEN-1:0]  RST_TRAP_PC   = '0;
    localparam logic [CNT_W-1:0] RST_STALL_CNT = '0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the ID instruction needs a register that the
// load currently in EX has not produced yet.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd_addr,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       hit
);

    logic rs1_match;
    logic rs2_match;

    // x0 never carries a hazard, so a load to rd=0 is ignored.
    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
        rs2_match = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
        hit       = ex_valid && ex_is_load && (ex_rd_addr != 5'd0) &&
                    (rs1_match || rs2_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and redirect controller: per-stage stall/flush, PC redirect
// for mispredicts and traps, trap drain behind a busy data access, and
// discard of a wrong-path fetch still outstanding at redirect.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mispredict,
    input  logic [XLEN-1:0]  ex_redirect_pc,
    input  logic             wb_except,
    input  logic [XLEN-1:0]  wb_trap_pc,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             pc_load,
    output logic [XLEN-1:0]  pc_target,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] trap_q;
    logic            trap_latch;
    logic            lu_hit;

    load_use_detect u_lu (
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd_addr  (ex_rd_addr),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hit         (lu_hit)
    );

    // Priority mux and next-state: trap > mispredict > mem_busy > load-use > if_busy.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        pc_load      = 1'b0;
        pc_target    = '0;
        trap_latch   = 1'b0;
        state_d      = state_q;

        case (state_q)
            DRAIN: begin
                // Trap waits for the in-flight data access; new events ignored.
                if (mem_busy) begin
                    {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
                end else begin
                    {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = 4'b1111;
                    pc_load   = 1'b1;
                    pc_target = trap_q;
                    state_d   = if_busy ? KILL : RUN;
                end
            end
            default: begin
                // KILL leaves once the outstanding wrong-path fetch has returned.
                if (state_q == KILL) state_d = if_busy ? KILL : RUN;

                if (wb_except && !mem_busy) begin
                    {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = 4'b1111;
                    pc_load   = 1'b1;
                    pc_target = wb_trap_pc;
                    state_d   = if_busy ? KILL : RUN;
                end else if (wb_except) begin
                    {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = 5'b11111;
                    trap_latch = 1'b1;
                    state_d    = DRAIN;
                end else if (ex_mispredict && !mem_busy) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    pc_load     = 1'b1;
                    pc_target   = ex_redirect_pc;
                    if (if_busy) state_d = KILL;
                end else if (mem_busy) begin
                    // A pending mispredict stays in EX and is taken once MEM completes.
                    {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
                    flush_mem_wb = 1'b1;
                end else if (lu_hit) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (if_busy) begin
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                end

                // Wrong-path fetch must never land in IF/ID; flush beats stall there.
                if (state_q == KILL) begin
                    flush_if_id = 1'b1;
                    stall_if_id = 1'b0;
                    if (if_busy && !pc_load) stall_pc = 1'b1;
                end
            end
        endcase
    end

    // State, latched trap vector and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            trap_q       <= RST_TRAP_PC;
            stall_cycles <= RST_STALL_CNT;
        end else begin
            state_q <= state_d;
            if (trap_latch) trap_q <= wb_trap_pc;
            if (stall_pc) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each vector pushes its hand-computed
// response into a queue; a monitor pops and compares once per cycle.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        if_busy;
        logic        mem_busy;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic        ex_valid;
        logic        ex_is_load;
        logic [4:0]  rd;
        logic        mis;
        logic [63:0] rpc;
        logic        exc;
        logic [63:0] tpc;
    } in_t;

    typedef struct packed {
        logic [4:0]  st;   // pc, if_id, id_ex, ex_mem, mem_wb
        logic [3:0]  fl;   // if_id, id_ex, ex_mem, mem_wb
        logic        ld;
        logic [63:0] tgt;
        logic [31:0] cnt;
        logic        chk;  // 0: only the counter is checked this cycle
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_busy, mem_busy;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic             id_use_rs1, id_use_rs2, ex_valid, ex_is_load;
    logic             ex_mispredict, wb_except;
    logic [XLEN-1:0]  ex_redirect_pc, wb_trap_pc;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic             pc_load;
    logic [XLEN-1:0]  pc_target;
    logic [CNT_W-1:0] stall_cycles;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
        .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
        .wb_except(wb_except), .wb_trap_pc(wb_trap_pc),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .pc_load(pc_load), .pc_target(pc_target), .stall_cycles(stall_cycles)
    );

    task automatic apply(input in_t v);
        rst            = v.rst;
        if_busy        = v.if_busy;
        mem_busy       = v.mem_busy;
        id_rs1_addr    = v.rs1;
        id_rs2_addr    = v.rs2;
        id_use_rs1     = v.use1;
        id_use_rs2     = v.use2;
        ex_valid       = v.ex_valid;
        ex_is_load     = v.ex_is_load;
        ex_rd_addr     = v.rd;
        ex_mispredict  = v.mis;
        ex_redirect_pc = v.rpc;
        wb_except      = v.exc;
        wb_trap_pc     = v.tpc;
    endtask

    // One cycle of stimulus: drive just after the edge, queue the expectation.
    task automatic go(input in_t v, input logic [4:0] st, input logic [3:0] fl,
                      input logic ld, input logic [63:0] tgt, input int cnt,
                      input logic chk = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.st = st; e.fl = fl; e.ld = ld; e.tgt = tgt; e.cnt = 32'(cnt); e.chk = chk;
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a fresh combinational response.
    initial begin
        exp_t        e;
        logic [4:0]  a_st;
        logic [3:0]  a_fl;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e    = q.pop_front();
                a_st = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
                a_fl = {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
                if (e.chk) begin
                    n_cmp++;
                    if ({a_st, a_fl, pc_load} !== {e.st, e.fl, e.ld}) begin
                        n_fail++;
                        $display("FAIL ctrl t=%0t: got st=%b fl=%b ld=%b, want st=%b fl=%b ld=%b",
                                 $time, a_st, a_fl, pc_load, e.st, e.fl, e.ld);
                    end
                    n_cmp++;
                    if (pc_target !== e.tgt) begin
                        n_fail++;
                        $display("FAIL pc_target t=%0t: got %h want %h", $time, pc_target, e.tgt);
                    end
                end
                n_cmp++;
                if (stall_cycles !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_cycles t=%0t: got %0d want %0d", $time, stall_cycles, e.cnt);
                end
            end
        end
    end

    initial begin
        in_t IDLE, v;
        IDLE = '0;
        apply('{rst: 1'b1, default: '0});

        // reset: outputs follow RUN with current inputs, counter held at 0
        v = IDLE; v.rst = 1;                   go(v, 5'b00000, 4'b0000, 0, 64'h0, 0);
        v = IDLE; v.rst = 1; v.if_busy = 1;    go(v, 5'b10000, 4'b1000, 0, 64'h0, 0);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 0);

        // load-use: x5 via rs2, rd=0, unused rs1, x5 via rs1
        v = IDLE; v.ex_valid = 1; v.ex_is_load = 1; v.rd = 5; v.rs2 = 5; v.use2 = 1;
        go(v, 5'b11000, 4'b0100, 0, 64'h0, 0);
        v.rd = 0;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 1);
        v.rd = 5; v.rs1 = 5; v.use1 = 0; v.rs2 = 7;
        go(v, 5'b00000, 4'b0000, 0, 64'h0, 1);
        v.use1 = 1;                            go(v, 5'b11000, 4'b0100, 0, 64'h0, 1);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 2);

        // mispredict with fetch idle stays in RUN
        v = IDLE; v.mis = 1; v.rpc = 64'h8000_1000;
        go(v, 5'b00000, 4'b1100, 1, 64'h8000_1000, 2);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 2);

        // mispredict with fetch outstanding: KILL for 3 busy cycles + release
        v = IDLE; v.mis = 1; v.rpc = 64'h8000_2000; v.if_busy = 1;
        go(v, 5'b00000, 4'b1100, 1, 64'h8000_2000, 2);
        v = IDLE; v.if_busy = 1;
        go(v, 5'b10000, 4'b1000, 0, 64'h0, 2);
        go(v, 5'b10000, 4'b1000, 0, 64'h0, 3);
        go(v, 5'b10000, 4'b1000, 0, 64'h0, 4);
        v = IDLE;                              go(v, 5'b00000, 4'b1000, 0, 64'h0, 5);
        go(v, 5'b00000, 4'b0000, 0, 64'h0, 5);

        // mem_busy, mispredict held behind it, then taken
        v = IDLE; v.mem_busy = 1;              go(v, 5'b11110, 4'b0001, 0, 64'h0, 5);
        v.mis = 1; v.rpc = 64'h8000_3000;      go(v, 5'b11110, 4'b0001, 0, 64'h0, 6);
        v.mem_busy = 0;                        go(v, 5'b00000, 4'b1100, 1, 64'h8000_3000, 7);

        // if_busy alone
        v = IDLE; v.if_busy = 1;               go(v, 5'b10000, 4'b1000, 0, 64'h0, 7);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 8);

        // trap behind 4 busy cycles; new events ignored during drain
        v = IDLE; v.exc = 1; v.tpc = 64'h8000_0100; v.mem_busy = 1;
        go(v, 5'b11111, 4'b0000, 0, 64'h0, 8);
        v.tpc = 64'h1234_5678; v.mis = 1; v.rpc = 64'h8000_9000;
        go(v, 5'b11111, 4'b0000, 0, 64'h0, 9);
        go(v, 5'b11111, 4'b0000, 0, 64'h0, 10);
        go(v, 5'b11111, 4'b0000, 0, 64'h0, 11);
        v = IDLE; v.tpc = 64'h0000_dead;       go(v, 5'b00000, 4'b1111, 1, 64'h8000_0100, 12);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 12);

        // trap and mispredict together: trap wins
        v = IDLE; v.exc = 1; v.tpc = 64'h8000_0200; v.mis = 1; v.rpc = 64'h8000_4000;
        go(v, 5'b00000, 4'b1111, 1, 64'h8000_0200, 12);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 12);

        // immediate trap with fetch outstanding goes through KILL
        v = IDLE; v.exc = 1; v.tpc = 64'h8000_0300; v.if_busy = 1;
        go(v, 5'b00000, 4'b1111, 1, 64'h8000_0300, 12);
        v = IDLE; v.if_busy = 1;               go(v, 5'b10000, 4'b1000, 0, 64'h0, 12);
        v = IDLE;                              go(v, 5'b00000, 4'b1000, 0, 64'h0, 13);
        go(v, 5'b00000, 4'b0000, 0, 64'h0, 13);

        // reset in the middle of a drain drops the pending trap
        v = IDLE; v.exc = 1; v.tpc = 64'h8000_0400; v.mem_busy = 1;
        go(v, 5'b11111, 4'b0000, 0, 64'h0, 13);
        v = IDLE; v.mem_busy = 1; v.rst = 1;   go(v, 5'b00000, 4'b0000, 0, 64'h0, 14, 1'b0);
        v = IDLE;                              go(v, 5'b00000, 4'b0000, 0, 64'h0, 0);
        go(v, 5'b00000, 4'b0000, 0, 64'h0, 0);

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
